// File: rtl/fifo_burst_writer.sv
// fifo_burst_writer: drains a FWFT FIFO into memory as bus bursts of at most maxBurstLength beats.
// Ports: clock/reset (sync, active-high); start/startAddress/wordCount command; fifoEmpty/fifoPopData/fifoPop FIFO pop side;
// busRequest/busGrant arbitration; busBeginTransaction/busAddress/busBurstSize address phase; busDataValid/busData/busBusy beats;
// busError slave error; busEndTransaction burst end; busy/done/error status.
// FIFO_BURST_WRITER_STATS_EN adds saturating statWords/statStalls counters.
module fifo_burst_writer #(
  parameter int bitWidth = 32,
  parameter int maxBurstLength = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic [31:0]         startAddress,
  input  logic [15:0]         wordCount,
  input  logic                fifoEmpty,
  input  logic [bitWidth-1:0] fifoPopData,
  output logic                fifoPop,
  output logic                busRequest,
  input  logic                busGrant,
  output logic                busBeginTransaction,
  output logic [31:0]         busAddress,
  output logic [7:0]          busBurstSize,
  output logic                busDataValid,
  output logic [bitWidth-1:0] busData,
  input  logic                busBusy,
  input  logic                busError,
  output logic                busEndTransaction,
  output logic                busy,
  output logic                done,
  output logic                error
`ifdef FIFO_BURST_WRITER_STATS_EN
  ,
  output logic [31:0]         statWords,
  output logic [31:0]         statStalls
`endif
);
  typedef enum logic [2:0] {ST_IDLE, ST_REQ, ST_BEGIN, ST_DATA, ST_END, ST_ABORT} state_t;
  localparam logic [8:0] max_len = 9'(maxBurstLength);
  state_t state, state_n;
  logic [31:0] addr;
  logic [15:0] remaining;
  logic [8:0] burst_len, burst_n, beats;
  logic in_data, beat, last_beat, final_burst;
  assign in_data = state == ST_DATA;
  assign busDataValid = in_data && !fifoEmpty;
  // an erroring cycle never consumes the FIFO head
  assign beat = busDataValid && !busBusy && !busError;
  assign fifoPop = beat;
  assign busData = in_data ? fifoPopData : '0;
  assign busBeginTransaction = state == ST_BEGIN;
  assign busEndTransaction = state == ST_END || state == ST_ABORT;
  assign last_beat = beat && beats == burst_len - 9'd1;
  assign final_burst = remaining == 16'(burst_len);
  assign burst_n = remaining < 16'(maxBurstLength) ? remaining[8:0] : max_len;
  always_ff @(posedge clock) begin
    state <= reset ? ST_IDLE : state_n;
  end
  always_comb begin
    state_n = state;
    unique case (state)
      ST_IDLE:  state_n = start && wordCount != '0 ? ST_REQ : ST_IDLE;
      ST_REQ:   state_n = busGrant ? ST_BEGIN : ST_REQ;
      ST_BEGIN: state_n = busError ? ST_ABORT : ST_DATA;
      ST_DATA:  state_n = busError ? ST_ABORT : last_beat ? ST_END : ST_DATA;
      ST_END:   state_n = final_burst ? ST_IDLE : ST_REQ;
      ST_ABORT: state_n = ST_IDLE;
      default:  state_n = ST_IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      addr <= '0;
      remaining <= '0;
      burst_len <= '0;
      beats <= '0;
      busRequest <= 1'b0;
      busAddress <= '0;
      busBurstSize <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      error <= 1'b0;
    end else begin
      busRequest <= state_n == ST_REQ;
      done <= 1'b0;
      if (state == ST_IDLE && start) begin
        if (wordCount == '0) done <= 1'b1;
        else begin
          addr <= startAddress & ~32'h3;
          remaining <= wordCount;
          error <= 1'b0;
          busy <= 1'b1;
        end
      end
      // address phase values are registered so they are stable throughout BEGIN
      if (state == ST_REQ && busGrant) begin
        busAddress <= addr;
        busBurstSize <= 8'(burst_n - 9'd1);
        burst_len <= burst_n;
        beats <= '0;
      end
      if (beat) beats <= beats + 9'd1;
      if (state == ST_END) begin
        addr <= addr + {21'd0, burst_len, 2'b00};
        remaining <= remaining - 16'(burst_len);
        if (final_burst) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
      if (state == ST_ABORT) begin
        error <= 1'b1;
        busy <= 1'b0;
      end
    end
  end
`ifdef FIFO_BURST_WRITER_STATS_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      statWords <= '0;
      statStalls <= '0;
    end else begin
      if (beat && statWords != '1) statWords <= statWords + 32'd1;
      if (in_data && (fifoEmpty || busBusy) && statStalls != '1) statStalls <= statStalls + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_fifo_burst_writer.sv
// tb_fifo_burst_writer: directed table plus corner-case sequences for fifo_burst_writer.
module tb_fifo_burst_writer;
  logic clock = 1'b0, reset = 1'b1, start = 1'b0;
  logic [31:0] startAddress = '0;
  logic [15:0] wordCount = '0;
  logic fifoEmpty, fifoPop, busRequest, busBeginTransaction, busDataValid, busEndTransaction, busy, done, error;
  logic [31:0] fifoPopData, busAddress, busData;
  logic [7:0] busBurstSize;
  logic busGrant = 1'b0, busBusy = 1'b0, busError = 1'b0;
`ifdef FIFO_BURST_WRITER_STATS_EN
  logic [31:0] statWords, statStalls;
`endif
  always #5 clock = ~clock;
  fifo_burst_writer dut (
    .clock(clock), .reset(reset), .start(start), .startAddress(startAddress), .wordCount(wordCount),
    .fifoEmpty(fifoEmpty), .fifoPopData(fifoPopData), .fifoPop(fifoPop), .busRequest(busRequest),
    .busGrant(busGrant), .busBeginTransaction(busBeginTransaction), .busAddress(busAddress),
    .busBurstSize(busBurstSize), .busDataValid(busDataValid), .busData(busData), .busBusy(busBusy),
    .busError(busError), .busEndTransaction(busEndTransaction), .busy(busy), .done(done), .error(error)
`ifdef FIFO_BURST_WRITER_STATS_EN
    , .statWords(statWords), .statStalls(statStalls)
`endif
  );
  // FIFO model: word n pushed is 0xA500_0000 + n, so pop order is checkable by index
  logic [31:0] mem [64];
  int rd = 0, wr = 0;
  assign fifoEmpty = rd == wr;
  assign fifoPopData = mem[rd % 64];
  // arbiter grants one cycle after seeing a request
  always @(posedge clock) begin
    busGrant <= busRequest;
    if (fifoPop) rd <= rd + 1;
  end
  logic [31:0] baddr [64];
  logic [7:0] bsize [64];
  int bbeats [64];
  logic [31:0] gotd [256];
  int nb = 0, ngot = 0, cur = 0, n_done = 0, n_req = 0, end_at_done = 0, viol = 0;
  always @(negedge clock) begin
    if (busBeginTransaction && nb < 64) begin
      baddr[nb] = busAddress;
      bsize[nb] = busBurstSize;
      cur = 0;
    end
    if (fifoPop) begin
      if (ngot < 256) gotd[ngot] = busData;
      ngot++;
      cur++;
      if (busBusy || fifoEmpty || busError) viol++;
    end
    if (busDataValid && fifoEmpty) viol++;
    if (busEndTransaction && nb < 64) begin
      bbeats[nb] = cur;
      nb++;
    end
    if (done) begin
      n_done++;
      end_at_done = nb;
    end
    if (busRequest) n_req++;
  end
  int checks = 0, errors = 0;
  task automatic chk(input string name, input logic [63:0] got_v, input logic [63:0] exp_v);
    checks++;
    if (got_v !== exp_v) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got_v, exp_v);
    end
  endtask
  task automatic drive;
    @(posedge clock);
    #1;
  endtask
  task automatic sample;
    @(negedge clock);
    #1;
  endtask
  task automatic push(input int n);
    for (int i = 0; i < n; i++) begin
      mem[wr % 64] = 32'hA500_0000 + 32'(wr);
      wr++;
    end
  endtask
  task automatic do_start(input logic [31:0] a, input logic [15:0] c);
    drive;
    start = 1'b1;
    startAddress = a;
    wordCount = c;
    drive;
    start = 1'b0;
  endtask
  task automatic wait_done(input int d0);
    for (int k = 0; k < 3000 && n_done == d0; k++) sample;
    chk("done_seen", 64'(n_done - d0), 64'd1);
  endtask
  task automatic wait_pops(input int g0, input int n);
    for (int k = 0; k < 200 && ngot - g0 < n; k++) sample;
    chk("pops_reached", 64'(ngot - g0), 64'(n));
  endtask
  task automatic check_data(input string name, input int from);
    int bad = 0;
    for (int j = from; j < ngot && j < 256; j++)
      if (gotd[j] !== 32'hA500_0000 + 32'(j)) bad++;
    chk(name, 64'(bad), 64'd0);
  endtask
  task automatic chk_zero(input string name);
    chk(name, {fifoPop, busRequest, busBeginTransaction, busDataValid, busEndTransaction, busy, done, error, busBurstSize}, 64'd0);
    chk(name, {busAddress, busData}, 64'd0);
  endtask
  typedef struct {
    logic [31:0] addr;
    logic [15:0] cnt;
    int n;
    logic [0:2][31:0] a;
    logic [0:2][7:0] s;
  } vec_t;
  vec_t vt [6];
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int d0, b0, g0, g1, r0;
    vt[0] = '{32'h0000_0100, 16'd5,  1, {32'h0000_0100, 32'h0, 32'h0}, {8'd4, 8'd0, 8'd0}};
    vt[1] = '{32'h0000_0100, 16'd40, 3, {32'h0000_0100, 32'h0000_0140, 32'h0000_0180}, {8'd15, 8'd15, 8'd7}};
    vt[2] = '{32'h0000_0203, 16'd16, 1, {32'h0000_0200, 32'h0, 32'h0}, {8'd15, 8'd0, 8'd0}};
    vt[3] = '{32'h0000_1000, 16'd17, 2, {32'h0000_1000, 32'h0000_1040, 32'h0}, {8'd15, 8'd0, 8'd0}};
    vt[4] = '{32'hFFFF_FFC0, 16'd20, 2, {32'hFFFF_FFC0, 32'h0000_0000, 32'h0}, {8'd15, 8'd3, 8'd0}};
    vt[5] = '{32'h0000_0010, 16'd1,  1, {32'h0000_0010, 32'h0, 32'h0}, {8'd0, 8'd0, 8'd0}};
    reset = 1'b1;
    drive;
    drive;
    reset = 1'b0;
    sample;
    chk_zero("reset_outputs");
    for (int v = 0; v < 6; v++) begin
      d0 = n_done;
      b0 = nb;
      g0 = ngot;
      push(int'(vt[v].cnt));
      do_start(vt[v].addr, vt[v].cnt);
      wait_done(d0);
      chk("burst_count", 64'(nb - b0), 64'(vt[v].n));
      for (int k = 0; k < vt[v].n; k++) begin
        chk("burst_addr", 64'(baddr[b0 + k]), 64'(vt[v].a[k]));
        chk("burst_size", 64'(bsize[b0 + k]), 64'(vt[v].s[k]));
        chk("burst_beats", 64'(bbeats[b0 + k]), 64'(vt[v].s[k]) + 64'd1);
      end
      chk("done_after_last_end", 64'(end_at_done), 64'(b0 + vt[v].n));
      chk("word_count", 64'(ngot - g0), 64'(vt[v].cnt));
      check_data("data_order", g0);
      sample;
      chk("idle_status", {busy, error}, 64'd0);
    end
    // FIFO runs dry mid-burst, then the slave stalls
    d0 = n_done;
    g0 = ngot;
    push(3);
    do_start(32'h0000_2000, 16'd10);
    wait_pops(g0, 3);
    repeat (3) begin
      sample;
      chk("stall_empty", {busDataValid, fifoPop}, 64'd0);
    end
    drive;
    busBusy = 1'b1;
    push(7);
    repeat (2) begin
      sample;
      chk("stall_busy", {busDataValid, fifoPop}, 64'b10);
      drive;
    end
    busBusy = 1'b0;
    wait_done(d0);
    chk("stall_words", 64'(ngot - g0), 64'd10);
    check_data("stall_data", g0);
    chk("stall_size", 64'(bsize[nb - 1]), 64'd9);
    // slave error on the third beat
    d0 = n_done;
    g0 = ngot;
    push(8);
    do_start(32'h0000_3000, 16'd8);
    wait_pops(g0, 2);
    drive;
    busError = 1'b1;
    sample;
    chk("err_nopop", 64'(fifoPop), 64'd0);
    drive;
    busError = 1'b0;
    sample;
    chk("err_end", 64'(busEndTransaction), 64'd1);
    sample;
    chk("err_flag", {error, busy, done}, 64'b100);
    chk("err_nodone", 64'(n_done - d0), 64'd0);
    chk("err_pops", 64'(ngot - g0), 64'd2);
    d0 = n_done;
    g1 = ngot;
    do_start(32'h0000_3100, 16'd6);
    sample;
    chk("err_cleared", {error, busy}, 64'b01);
    wait_done(d0);
    chk("err_restart_words", 64'(ngot - g1), 64'd6);
    check_data("err_restart_data", g0);
    // zero-length command
    d0 = n_done;
    r0 = n_req;
    do_start(32'h0, 16'd0);
    sample;
    chk("zero_done", {done, busy}, 64'b10);
    sample;
    chk("zero_pulse", 64'(done), 64'd0);
    chk("zero_noreq", 64'(n_req - r0), 64'd0);
    // a second start while busy is ignored
    d0 = n_done;
    b0 = nb;
    g0 = ngot;
    push(4);
    do_start(32'h0000_0400, 16'd4);
    sample;
    chk("ign_busy", 64'(busy), 64'd1);
    drive;
    start = 1'b1;
    startAddress = 32'h0000_0800;
    wordCount = 16'd9;
    drive;
    start = 1'b0;
    wait_done(d0);
    repeat (5) sample;
    chk("ign_bursts", 64'(nb - b0), 64'd1);
    chk("ign_addr", 64'(baddr[b0]), 64'h400);
    chk("ign_size", 64'(bsize[b0]), 64'd3);
    chk("ign_words", 64'(ngot - g0), 64'd4);
    chk("ign_done", 64'(n_done - d0), 64'd1);
    chk("ign_idle", 64'(busy), 64'd0);
    // reset in the middle of DATA, then a clean restart
    g0 = ngot;
    push(8);
    do_start(32'h0000_5000, 16'd8);
    wait_pops(g0, 2);
    drive;
    reset = 1'b1;
    busBusy = 1'b1;
    drive;
    reset = 1'b0;
    busBusy = 1'b0;
    sample;
    chk_zero("midreset_outputs");
    chk("midreset_pops", 64'(ngot - g0), 64'd2);
    d0 = n_done;
    g1 = ngot;
    do_start(32'h0000_5100, 16'd6);
    wait_done(d0);
    chk("midreset_words", 64'(ngot - g1), 64'd6);
    check_data("midreset_data", g0);
    chk("midreset_addr", 64'(baddr[nb - 1]), 64'h5100);
    chk("midreset_size", 64'(bsize[nb - 1]), 64'd5);
    chk("protocol", 64'(viol), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
